crypto_incoming_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-port 4096 x 32 incoming-data RAM of the crypto test system. Shares the RAM between the host port (A, Avalon-MM from the processor/bridge) and the crypto engine fetch port (B). Uses bounded round-robin with a burst-hold limit and returns read data with one-cycle latency to whichever port issued the read.

---
 rtl/crypto_mem_pkg.sv | 17 +
 rtl/crypto_rr_hold_arbiter.sv | 78 +++++++
 rtl/crypto_incoming_mem_arbiter.sv | 115 +++++++++++
 tb/tb_crypto_incoming_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_mem_pkg.sv
// ---------------------------------------------------------------------------
// crypto_mem_pkg
// Shared definitions for the crypto test system incoming-data RAM path:
// requester port identifiers and RAM geometry.
// ---------------------------------------------------------------------------
package crypto_mem_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  localparam int MEM_WORDS  = 4096;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;

endpackage

// File: rtl/crypto_rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// crypto_rr_hold_arbiter
// Two-requester round-robin grant with a burst-hold limit. The holder keeps
// the grant under contention until it has run MAX_HOLD consecutive cycles,
// then the other port takes over. The grant is combinational from the
// current requests and the registered last/streak state.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   a_req, b_req        request from port A / port B
//   gnt_vld             a port is granted this cycle
//   gnt_port            which port is granted (valid with gnt_vld)
// ---------------------------------------------------------------------------
module crypto_rr_hold_arbiter
  import crypto_mem_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  a_req,
  input  logic  b_req,
  output logic  gnt_vld,
  output port_e gnt_port
);

  localparam int STREAK_W = 8;
  localparam logic [STREAK_W-1:0] HOLD_MAX = STREAK_W'(MAX_HOLD);

  port_e               last;
  logic [STREAK_W-1:0] streak;
  port_e               other;

  // Saturating increment of the run length.
  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] s);
    if (s >= HOLD_MAX) return HOLD_MAX;
    return s + 1'b1;
  endfunction

  assign other = (last == PORT_A) ? PORT_B : PORT_A;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = PORT_A;
    if (!reset) begin
      if (a_req && b_req) begin
        gnt_vld = 1'b1;
        // A non-zero streak means the previous cycle was granted to last.
        if ((streak != '0) && (streak < HOLD_MAX)) gnt_port = last;
        else                                       gnt_port = other;
      end else if (a_req) begin
        gnt_vld  = 1'b1;
        gnt_port = PORT_A;
      end else if (b_req) begin
        gnt_vld  = 1'b1;
        gnt_port = PORT_B;
      end
    end
  end

  // last = B out of reset so A wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last   <= PORT_B;
      streak <= '0;
    end else if (gnt_vld) begin
      if (gnt_port == last) begin
        streak <= sat_inc(streak);
      end else begin
        last   <= gnt_port;
        streak <= STREAK_W'(1);
      end
    end else begin
      streak <= '0;
    end
  end

endmodule

// File: rtl/crypto_incoming_mem_arbiter.sv
// ---------------------------------------------------------------------------
// crypto_incoming_mem_arbiter
// Shares the single-port 4096 x 32 incoming-data RAM between the host port
// (A, Avalon-MM) and the crypto engine fetch port (B). One access per cycle
// reaches the RAM; read data returns one cycle after acceptance, tagged to
// the port that issued the read.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   {a,b}_address/byteenable/read/write/writedata   requester inputs
//   {a,b}_waitrequest               request not accepted this cycle
//   {a,b}_readdata/readdatavalid    read return (1-cycle latency)
//   mem_address/byteenable/chipselect/write/writedata/clken  RAM controls
//   mem_readdata                    RAM q, valid the cycle after address
// ---------------------------------------------------------------------------
module crypto_incoming_mem_arbiter
  import crypto_mem_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int ADDR_W   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [MEM_BE_W-1:0]   a_byteenable,
  input  logic                  a_read,
  input  logic                  a_write,
  input  logic [MEM_DATA_W-1:0] a_writedata,
  output logic                  a_waitrequest,
  output logic [MEM_DATA_W-1:0] a_readdata,
  output logic                  a_readdatavalid,
  input  logic [ADDR_W-1:0]     b_address,
  input  logic [MEM_BE_W-1:0]   b_byteenable,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [MEM_DATA_W-1:0] b_writedata,
  output logic                  b_waitrequest,
  output logic [MEM_DATA_W-1:0] b_readdata,
  output logic                  b_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [MEM_BE_W-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [MEM_DATA_W-1:0] mem_writedata,
  output logic                  mem_clken,
  input  logic [MEM_DATA_W-1:0] mem_readdata
);

  logic  a_req, b_req;
  logic  gnt_vld;
  port_e gnt_port;
  logic  a_gnt, b_gnt;
  logic  rd_acc;
  logic  rd_pend;
  port_e rd_owner;

  assign a_req = a_read | a_write;
  assign b_req = b_read | b_write;

  crypto_rr_hold_arbiter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .b_req    (b_req),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  assign a_gnt = gnt_vld & (gnt_port == PORT_A);
  assign b_gnt = gnt_vld & (gnt_port == PORT_B);

  // Idle ports see waitrequest low; everything stalls while in reset.
  assign a_waitrequest = reset | (a_req & ~a_gnt);
  assign b_waitrequest = reset | (b_req & ~b_gnt);

  assign mem_clken = ~reset;

  // Write wins over a simultaneous read, so such a cycle never starts a read.
  always_comb begin
    mem_address    = a_address;
    mem_byteenable = a_byteenable;
    mem_writedata  = a_writedata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    rd_acc         = 1'b0;
    if (a_gnt) begin
      mem_chipselect = 1'b1;
      mem_write      = a_write;
      rd_acc         = a_read & ~a_write;
    end else if (b_gnt) begin
      mem_address    = b_address;
      mem_byteenable = b_byteenable;
      mem_writedata  = b_writedata;
      mem_chipselect = 1'b1;
      mem_write      = b_write;
      rd_acc         = b_read & ~b_write;
    end
  end

  // Read return stage: RAM q arrives one cycle after the accepted read.
  always_ff @(posedge clk) begin
    if (reset) rd_pend <= 1'b0;
    else       rd_pend <= rd_acc;
    rd_owner <= gnt_port;
  end

  // Gating with reset drops a return that was in flight when reset arrived.
  assign a_readdatavalid = rd_pend & ~reset & (rd_owner == PORT_A);
  assign b_readdatavalid = rd_pend & ~reset & (rd_owner == PORT_B);
  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;

endmodule

// File: tb/tb_crypto_incoming_mem_arbiter.sv
module tb_crypto_incoming_mem_arbiter;
  import crypto_mem_pkg::*;

  localparam int MAX_HOLD = 4;
  localparam int ADDR_W   = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] a_address = '0, b_address = '0;
  logic [3:0]  a_byteenable = '0, b_byteenable = '0;
  logic        a_read = 1'b0, a_write = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [31:0] a_writedata = '0, b_writedata = '0;
  logic        a_waitrequest, b_waitrequest;
  logic [31:0] a_readdata, b_readdata;
  logic        a_readdatavalid, b_readdatavalid;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crypto_incoming_mem_arbiter #(.MAX_HOLD(MAX_HOLD), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read),
    .a_write(a_write), .a_writedata(a_writedata), .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read),
    .b_write(b_write), .b_writedata(b_writedata), .b_waitrequest(b_waitrequest),
    .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // External single-port RAM with one-cycle read latency.
  logic [31:0] ram [0:4095];
  logic [31:0] ram_q = '0;
  assign mem_readdata = ram_q;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= be_merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           ram_q <= ram[mem_address];
    end
  end

  // Reference model: contents seen by requesters, who currently holds the
  // RAM and for how many consecutive cycles, and the expected read return.
  logic [31:0] ref_mem [0:4095];
  int          m_last = 1;
  int          m_run = 0;
  bit          m_pend = 0;
  int          m_owner = 0;
  logic [31:0] m_data = '0;
  int          wait_a = 0, wait_b = 0;

  always @(negedge clk) begin
    bit ar, br, wr;
    int g;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    if (reset) begin
      chk("rst_a_wait", a_waitrequest, 1);
      chk("rst_b_wait", b_waitrequest, 1);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_clken", mem_clken, 0);
      chk("rst_a_rdv", a_readdatavalid, 0);
      chk("rst_b_rdv", b_readdatavalid, 0);
      m_last = 1; m_run = 0; m_pend = 0; wait_a = 0; wait_b = 0;
    end else begin
      chk("clken", mem_clken, 1);
      chk("a_rdv", a_readdatavalid, (m_pend && m_owner == 0));
      chk("b_rdv", b_readdatavalid, (m_pend && m_owner == 1));
      if (m_pend) chk(m_owner == 0 ? "a_rdata" : "b_rdata",
                      m_owner == 0 ? a_readdata : b_readdata, m_data);
      ar = a_read | a_write;
      br = b_read | b_write;
      g = -1;
      if (ar && br) g = (m_run > 0 && m_run < MAX_HOLD) ? m_last : 1 - m_last;
      else if (ar)  g = 0;
      else if (br)  g = 1;
      chk("a_wait", a_waitrequest, (ar && g != 0));
      chk("b_wait", b_waitrequest, (br && g != 1));
      chk("cs", mem_chipselect, (g >= 0));
      m_pend = 0;
      if (g >= 0) begin
        wr   = (g == 0) ? a_write : b_write;
        addr = (g == 0) ? a_address : b_address;
        be   = (g == 0) ? a_byteenable : b_byteenable;
        wd   = (g == 0) ? a_writedata : b_writedata;
        chk("mem_addr", mem_address, addr);
        chk("mem_we", mem_write, wr);
        if (wr) begin
          chk("mem_wd", mem_writedata, wd);
          chk("mem_be", mem_byteenable, be);
          ref_mem[addr] = be_merge(ref_mem[addr], wd, be);
        end else begin
          m_pend = 1; m_owner = g; m_data = ref_mem[addr];
        end
        if (g == m_last) m_run = (m_run + 1 > MAX_HOLD) ? MAX_HOLD : m_run + 1;
        else begin m_last = g; m_run = 1; end
      end else begin
        chk("mem_we_idle", mem_write, 0);
        m_run = 0;
      end
      wait_a = (ar && g != 0) ? wait_a + 1 : 0;
      wait_b = (br && g != 1) ? wait_b + 1 : 0;
      if (wait_a > 0) chk("fair_a", (wait_a <= MAX_HOLD), 1);
      if (wait_b > 0) chk("fair_b", (wait_b <= MAX_HOLD), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1; idle();
    repeat (n) step();
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    do_reset(3);

    // A write then read back.
    a_address = 12'h010; a_byteenable = 4'hF; a_writedata = 32'hDEADBEEF; a_write = 1;
    step();
    a_write = 0; a_read = 1;
    step();
    idle(); #2;
    chk("dir_a_rdv", a_readdatavalid, 1);
    chk("dir_b_rdv", b_readdatavalid, 0);
    chk("dir_a_rdata", a_readdata, 32'hDEADBEEF);
    step();

    // B partial write over zero, then read.
    b_address = 12'h020; b_byteenable = 4'b0101; b_writedata = 32'hAABBCCDD; b_write = 1;
    step();
    b_write = 0; b_read = 1;
    step();
    idle(); #2;
    chk("dir_b_rdv_be", b_readdatavalid, 1);
    chk("dir_be_rdata", b_readdata, 32'h00BB00DD);
    step();

    // Simultaneous first request after reset, then sustained contention.
    do_reset(1);
    a_address = 12'h010; b_address = 12'h020; a_read = 1; b_read = 1;
    #2;
    chk("first_a_wait", a_waitrequest, 0);
    chk("first_b_wait", b_waitrequest, 1);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) #2;
      chk("pattern_a_wait", a_waitrequest, ((i / MAX_HOLD) % 2 == 1));
      step();
    end
    idle(); step();

    // Cross-port ordering at the top address.
    do_reset(1);
    a_address = 12'hFFF; a_byteenable = 4'hF; a_writedata = 32'h12345678; a_write = 1;
    b_address = 12'hFFF; b_read = 1;
    #2;
    chk("xport_b_wait", b_waitrequest, 1);
    step();
    a_write = 0;
    #2;
    chk("xport_b_gnt", b_waitrequest, 0);
    step();
    idle(); #2;
    chk("xport_b_rdv", b_readdatavalid, 1);
    chk("xport_b_rdata", b_readdata, 32'h12345678);
    step();

    // Reset arriving the cycle after a granted read.
    a_address = 12'h010; a_read = 1;
    step();
    idle(); reset = 1;
    #2;
    chk("rstrd_a_rdv", a_readdatavalid, 0);
    chk("rstrd_b_rdv", b_readdatavalid, 0);
    step();
    reset = 0;
    #2;
    chk("post_rst_a_rdv", a_readdatavalid, 0);
    step();

    // Randomized traffic, including the illegal read+write combination.
    for (int i = 0; i < 3000; i++) begin
      int ka, kb;
      ka = $urandom_range(0, 9);
      kb = $urandom_range(0, 9);
      a_read  = (ka inside {[1:4]}) || ka == 9;
      a_write = (ka inside {[5:7]}) || ka == 9;
      b_read  = (kb inside {[1:4]}) || kb == 9;
      b_write = (kb inside {[5:7]}) || kb == 9;
      a_address = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      b_address = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      a_byteenable = 4'($urandom);
      b_byteenable = 4'($urandom);
      a_writedata = $urandom;
      b_writedata = $urandom;
      if (i == 1500) reset = 1;
      if (i == 1502) reset = 0;
      step();
    end
    idle(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
